// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, state encoding and the round-robin search helper
// for the 16-way muxed round-robin arbiter.
package mux_rr_arbiter_pkg;

    localparam int N_REQ         = 16;
    localparam int SEL_W         = 4;
    localparam int CNT_W         = 4;
    localparam int DEFAULT_BURST = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // Walks offsets from the far end back toward ptr so the last hit kept
    // is the first set request at or after ptr in circular order.
    function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [SEL_W-1:0] ptr);
        rr_pick_t         pick;
        logic [SEL_W-1:0] idx;
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                pick.found = 1'b1;
                pick.idx   = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic mux4(input logic [3:0] d, input logic [1:0] sel);
        logic y;
        case (sel)
            2'd0:    y = d[0];
            2'd1:    y = d[1];
            2'd2:    y = d[2];
            default: y = d[3];
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bundle: request/data lines in, grant/select/channel out.
interface mux_rr_arbiter_if;
    import mux_rr_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] w;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] s;
    logic             f;
    logic             valid;

    modport master (
        output req,
        output w,
        input  gnt,
        input  s,
        input  f,
        input  valid
    );

    modport slave (
        input  req,
        input  w,
        output gnt,
        output s,
        output f,
        output valid
    );

endinterface

// File: rtl/mux_rr_arbiter_mux16_sel.sv
// 16:1 single-bit channel mux, built as a two-level tree of 4:1 muxes
// (low select bits pick within each group, high bits pick the group).
module mux16_sel
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] w,
    input  logic [SEL_W-1:0] s,
    output logic             f
);

    logic [3:0] lvl1;

    for (genvar j = 0; j < 4; j++) begin : g_lvl1
        assign lvl1[j] = mux4(w[4*j +: 4], s[1:0]);
    end

    assign f = mux4(lvl1, s[3:2]);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter over 16 requesters with a per-grant burst limit;
// the current grantee's data bit is steered onto the shared channel f.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int BURST = DEFAULT_BURST
)
(
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [SEL_W-1:0] s_q,     s_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [SEL_W-1:0] next_ptr;
    rr_pick_t         pick_idle;
    rr_pick_t         pick_rel;

    // On release the search restarts just past the grantee, so a sole
    // requester that is still asking wraps back around to itself.
    assign next_ptr  = s_q + 1'b1;
    assign pick_idle = rr_pick(bus.req, ptr_q);
    assign pick_rel  = rr_pick(bus.req, next_ptr);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    state_d = BUSY;
                    s_d     = pick_idle.idx;
                    cnt_d   = 4'd1;
                end
            end
            BUSY: begin
                if (bus.req[s_q] && (cnt_q < BURST_CNT)) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    ptr_d = next_ptr;
                    if (pick_rel.found) begin
                        s_d   = pick_rel.idx;
                        cnt_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid = (state_q == BUSY);
    assign bus.gnt   = (state_q == BUSY) ? (N_REQ'(1) << s_q) : '0;
    assign bus.s     = s_q;

    mux16_sel u_mux (
        .w (bus.w),
        .s (s_q),
        .f (bus.f)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared against a behavioural round-robin model kept in the bench.
module tb_mux_rr_arbiter;

    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst;

    int errCount   = 0;
    int checkCount = 0;

    bit mBusy;
    int mPtr;
    int mS;
    int mCnt;

    mux_rr_arbiter_if bus();

    mux_rr_arbiter #(.BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rrFind(input logic [15:0] rq, input int from);
        for (int k = 0; k < 16; k++) begin
            if (rq[(from + k) % 16]) return (from + k) % 16;
        end
        return -1;
    endfunction

    // Arbitration rules stated directly: grant first requester from ptr,
    // keep it while it asks and the burst is not used up, then rotate.
    function automatic void modelStep(input bit r, input logic [15:0] rq);
        int win;
        if (r) begin
            mBusy = 1'b0; mPtr = 0; mS = 0; mCnt = 0;
        end else if (!mBusy) begin
            win = rrFind(rq, mPtr);
            if (win >= 0) begin
                mBusy = 1'b1; mS = win; mCnt = 1;
            end
        end else if (rq[mS] && mCnt < BURST) begin
            mCnt++;
        end else begin
            mPtr = (mS + 1) % 16;
            win  = rrFind(rq, mPtr);
            if (win >= 0) begin
                mS = win; mCnt = 1;
            end else begin
                mBusy = 1'b0; mCnt = 0;
            end
        end
    endfunction

    task automatic applyStimulus(input bit r, input logic [15:0] rq, input logic [15:0] ww);
        rst     = r;
        bus.req = rq;
        bus.w   = ww;
        @(posedge clk);
        modelStep(r, rq);
        #1;
        checkOutput("model_gnt", 32'(bus.gnt), mBusy ? (32'(1) << mS) : 32'h0);
        checkOutput("model_valid", 32'(bus.valid), 32'(mBusy));
        if (mBusy) begin
            checkOutput("model_s", 32'(bus.s), 32'(mS));
            checkOutput("model_f", 32'(bus.f), 32'(ww[mS]));
        end
    endtask

    initial begin
        // Reset held with every line requesting, then released.
        applyStimulus(1'b1, 16'hFFFF, 16'h0000);
        applyStimulus(1'b1, 16'hFFFF, 16'h0000);
        checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
        checkOutput("rst_valid", 32'(bus.valid), 32'h0);
        checkOutput("rst_s", 32'(bus.s), 32'h0);
        applyStimulus(1'b0, 16'hFFFF, 16'h0000);
        checkOutput("rel_gnt", 32'(bus.gnt), 32'h0001);
        checkOutput("rel_s", 32'(bus.s), 32'h0);

        // Two requesters alternate in bursts with no idle bubble.
        applyStimulus(1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 16'h0005, 16'h0000);
            checkOutput("burst_gnt", 32'(bus.gnt), (i < 4) ? 32'h0001 : (i < 8) ? 32'h0004 : 32'h0001);
        end

        applyStimulus(1'b1, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 16'h0100, 16'h0000);
        checkOutput("drop_gnt0", 32'(bus.gnt), 32'h0100);
        applyStimulus(1'b0, 16'h0100, 16'h0000);
        checkOutput("drop_gnt1", 32'(bus.gnt), 32'h0100);
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        checkOutput("drop_idle", 32'(bus.valid), 32'h0);
        applyStimulus(1'b0, 16'h0101, 16'h0000);
        checkOutput("drop_regnt", 32'(bus.gnt), 32'h0001);

        applyStimulus(1'b1, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 16'h4000, 16'h0000);
        checkOutput("wrap_g14", 32'(bus.gnt), 32'h4000);
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 16'h8001, 16'h0000);
        checkOutput("wrap_g15", 32'(bus.gnt), 32'h8000);
        applyStimulus(1'b0, 16'h0001, 16'h0000);
        checkOutput("wrap_g0", 32'(bus.gnt), 32'h0001);

        // Sole requester across several burst boundaries keeps the channel.
        applyStimulus(1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 16'h0020, (i % 2 == 0) ? 16'h0020 : 16'hFFDF);
            checkOutput("data_f", 32'(bus.f), (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput("data_valid", 32'(bus.valid), 32'h1);
            checkOutput("data_gnt", 32'(bus.gnt), 32'h0020);
        end

        applyStimulus(1'b1, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 16'h0010, 16'h0000);
        applyStimulus(1'b0, 16'h0010, 16'h0000);
        applyStimulus(1'b1, 16'h0010, 16'h0000);
        checkOutput("midrst_gnt", 32'(bus.gnt), 32'h0);
        checkOutput("midrst_valid", 32'(bus.valid), 32'h0);
        applyStimulus(1'b0, 16'h0010, 16'h0000);
        checkOutput("midrst_regnt", 32'(bus.gnt), 32'h0010);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'h0030, 16'h0000);
            checkOutput("midrst_cnt", 32'(bus.gnt), (i < 3) ? 32'h0010 : 32'h0020);
        end

        applyStimulus(1'b1, 16'h0000, 16'h0000);
        for (int i = 0; i < 500; i++) begin
            automatic bit          r  = ($urandom_range(0, 49) == 0);
            automatic logic [15:0] rq = 16'($urandom & $urandom);
            automatic logic [15:0] ww = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 16'h0;
            applyStimulus(r, rq, ww);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
